// File: rtl/baccarat_pkg.sv
// Shared baccarat card types, constants, glyphs and scoring helpers.
package baccarat_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_EMPTY = 4'd0;
  localparam card_t CARD_ACE   = 4'd1;
  localparam card_t CARD_KING  = 4'd13;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_J     = 7'b1100001;
  localparam logic [6:0] SEG_Q     = 7'b0011000;
  localparam logic [6:0] SEG_H     = 7'b0001001;

  // Face cards, empty slots and out-of-range codes all score zero
  function automatic logic [3:0] card_value(input card_t card);
    if (card >= 4'd1 && card <= 4'd9) return card;
    return 4'd0;
  endfunction

  function automatic logic [3:0] hand_score(input card_t c1, input card_t c2, input card_t c3);
    logic [4:0] sum;
    sum = {1'b0, card_value(c1)} + {1'b0, card_value(c2)} + {1'b0, card_value(c3)};
    if (sum >= 5'd20)      sum = sum - 5'd20;
    else if (sum >= 5'd10) sum = sum - 5'd10;
    return sum[3:0];
  endfunction

endpackage

// File: rtl/card7seg.sv
// Combinational card code to active-low seven-segment glyph decoder.
module card7seg
  import baccarat_pkg::*;
(
  input  card_t      card,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (card)
      4'd1:    seg = SEG_A;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      4'd10:   seg = SEG_0;
      4'd11:   seg = SEG_J;
      4'd12:   seg = SEG_Q;
      4'd13:   seg = SEG_H;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/hand_datapath.sv
// Baccarat hand datapath: six card slots, hand scores and per-slot displays.
// Define HAND_DATAPATH_EXT_CARD_EN to take cards from new_card instead of the internal shoe.
module hand_datapath
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
`ifdef HAND_DATAPATH_EXT_CARD_EN
  input  logic [3:0] new_card,
`endif
  output logic [3:0] pcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [2:0] cards_dealt,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5
);

  logic [5:0] load_vec;
  card_t      capture_card;
  card_t      slot_reg [6];
  logic [6:0] hex_seg  [6];
  logic [2:0] cards_dealt_reg;

  assign load_vec = {load_dcard3, load_dcard2, load_dcard1,
                     load_pcard3, load_pcard2, load_pcard1};

`ifdef HAND_DATAPATH_EXT_CARD_EN
  // Codes 14-15 are not real cards; store them as an empty slot
  assign capture_card = (new_card > CARD_KING) ? CARD_EMPTY : new_card;
`else
  card_t shoe_reg;

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb)                  shoe_reg <= CARD_ACE;
    else if (shoe_reg == CARD_KING) shoe_reg <= CARD_ACE;
    else                          shoe_reg <= shoe_reg + 4'd1;
  end

  assign capture_card = shoe_reg;
`endif

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_slot
      always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb)          slot_reg[gi] <= CARD_EMPTY;
        else if (load_vec[gi]) slot_reg[gi] <= capture_card;
      end

      card7seg u_card7seg (
        .card (slot_reg[gi]),
        .seg  (hex_seg[gi])
      );
    end
  endgenerate

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb)
      cards_dealt_reg <= 3'd0;
    else if ((|load_vec) && (cards_dealt_reg != 3'd6))
      cards_dealt_reg <= cards_dealt_reg + 3'd1;
  end

  assign cards_dealt = cards_dealt_reg;
  assign pcard3      = slot_reg[2];
  assign pscore      = hand_score(slot_reg[0], slot_reg[1], slot_reg[2]);
  assign dscore      = hand_score(slot_reg[3], slot_reg[4], slot_reg[5]);

  assign HEX0 = hex_seg[0];
  assign HEX1 = hex_seg[1];
  assign HEX2 = hex_seg[2];
  assign HEX3 = hex_seg[3];
  assign HEX4 = hex_seg[4];
  assign HEX5 = hex_seg[5];

endmodule

// File: tb/tb_hand_datapath.sv
// Self-checking bench for hand_datapath against a card-level reference model.
module tb_hand_datapath;

  logic       slow_clock = 1'b0;
  logic       resetb = 1'b0;
  logic       load_pcard1 = 0, load_pcard2 = 0, load_pcard3 = 0;
  logic       load_dcard1 = 0, load_dcard2 = 0, load_dcard3 = 0;
  logic [3:0] new_card = 4'd0;
  logic [3:0] pcard3, pscore, dscore;
  logic [2:0] cards_dealt;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [6:0] hex_o [6];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int slot_m [6];
  int edges_m;
  int dealt_m;

  hand_datapath dut (
    .slow_clock  (slow_clock),
    .resetb      (resetb),
    .load_pcard1 (load_pcard1),
    .load_pcard2 (load_pcard2),
    .load_pcard3 (load_pcard3),
    .load_dcard1 (load_dcard1),
    .load_dcard2 (load_dcard2),
    .load_dcard3 (load_dcard3),
`ifdef HAND_DATAPATH_EXT_CARD_EN
    .new_card    (new_card),
`endif
    .pcard3      (pcard3),
    .pscore      (pscore),
    .dscore      (dscore),
    .cards_dealt (cards_dealt),
    .HEX0        (HEX0),
    .HEX1        (HEX1),
    .HEX2        (HEX2),
    .HEX3        (HEX3),
    .HEX4        (HEX4),
    .HEX5        (HEX5)
  );

  assign hex_o[0] = HEX0;
  assign hex_o[1] = HEX1;
  assign hex_o[2] = HEX2;
  assign hex_o[3] = HEX3;
  assign hex_o[4] = HEX4;
  assign hex_o[5] = HEX5;

  always #5 slow_clock = ~slow_clock;

  function automatic int face(input int v);
    return (v >= 1 && v <= 9) ? v : 0;
  endfunction

  function automatic int pscore_m();
    return (face(slot_m[0]) + face(slot_m[1]) + face(slot_m[2])) % 10;
  endfunction

  function automatic int dscore_m();
    return (face(slot_m[3]) + face(slot_m[4]) + face(slot_m[5])) % 10;
  endfunction

  function automatic logic [6:0] glyph_m(input int v);
    case (v)
      1:  return 7'b0001000;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b1000000;
      11: return 7'b1100001;
      12: return 7'b0011000;
      13: return 7'b0001001;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 6; i++) slot_m[i] = 0;
    edges_m = 0;
    dealt_m = 0;
  endtask

  // Called with the clock low: hold reset for one negedge, release on the next
  task automatic do_reset();
    resetb = 1'b0;
    model_clear();
    @(negedge slow_clock);
    resetb = 1'b1;
  endtask

  // ld bit order: {d3,d2,d1,p3,p2,p1}; drives one edge and returns at the following negedge
  task automatic drive(input logic [5:0] ld, input logic [3:0] card);
    int v;
    {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = ld;
    new_card = card;
    @(posedge slow_clock);
`ifdef HAND_DATAPATH_EXT_CARD_EN
    v = (card > 4'd13) ? 0 : int'(card);
`else
    v = (edges_m % 13) + 1;
`endif
    for (int i = 0; i < 6; i++) if (ld[i]) slot_m[i] = v;
    if (ld != 6'd0 && dealt_m < 6) dealt_m++;
    edges_m++;
    @(negedge slow_clock);
    {load_dcard3, load_dcard2, load_dcard1, load_pcard3, load_pcard2, load_pcard1} = 6'd0;
  endtask

  task automatic test_reset();
    @(negedge slow_clock);
    #1;
    n_checks++;
    if ({pcard3, pscore, dscore} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_scores got p3=%0d ps=%0d ds=%0d required 0 0 0", pcard3, pscore, dscore);
    end
    n_checks++;
    if (cards_dealt !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_dealt got %0d required 0", cards_dealt);
    end
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (hex_o[i] !== 7'b1111111) begin
        n_fail++;
        $display("FAIL reset_hex%0d got %b required 1111111", i, hex_o[i]);
      end
    end
    @(negedge slow_clock);
    do_reset();
  endtask

  task automatic test_deal_order();
    @(negedge slow_clock);
    do_reset();
    for (int i = 0; i < 6; i++) drive(6'(1 << i), 4'(i + 1));
    n_checks++;
    if (pscore !== 4'd6 || pscore !== 4'(pscore_m())) begin
      n_fail++;
      $display("FAIL deal_pscore got %0d required 6", pscore);
    end
    n_checks++;
    if (dscore !== 4'd5) begin
      n_fail++;
      $display("FAIL deal_dscore got %0d required 5", dscore);
    end
    n_checks++;
    if (pcard3 !== 4'd3) begin
      n_fail++;
      $display("FAIL deal_pcard3 got %0d required 3", pcard3);
    end
    n_checks++;
    if (cards_dealt !== 3'd6) begin
      n_fail++;
      $display("FAIL deal_dealt got %0d required 6", cards_dealt);
    end
    n_checks++;
    if (HEX0 !== 7'b0001000) begin
      n_fail++;
      $display("FAIL deal_hex0 got %b required 0001000", HEX0);
    end
    drive(6'b000001, 4'd7);
    n_checks++;
    if (cards_dealt !== 3'd6) begin
      n_fail++;
      $display("FAIL deal_saturate got %0d required 6", cards_dealt);
    end
    $display("deal_order: pscore=%0d dscore=%0d dealt=%0d", pscore, dscore, cards_dealt);
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(6'b001001, 4'd1);
    n_checks++;
    if (pscore !== 4'd1 || dscore !== 4'd1 || cards_dealt !== 3'd1) begin
      n_fail++;
      $display("FAIL simul got ps=%0d ds=%0d dealt=%0d required 1 1 1", pscore, dscore, cards_dealt);
    end
    $display("simultaneous: pscore=%0d dscore=%0d dealt=%0d", pscore, dscore, cards_dealt);
  endtask

`ifndef HAND_DATAPATH_EXT_CARD_EN
  task automatic test_shoe_wrap();
    do_reset();
    repeat (12) drive(6'd0, 4'd0);
    drive(6'b000001, 4'd0);
    n_checks++;
    if (HEX0 !== 7'b0001001 || pscore !== 4'd0) begin
      n_fail++;
      $display("FAIL wrap_king got hex0=%b ps=%0d required 0001001 0", HEX0, pscore);
    end
    drive(6'b000010, 4'd0);
    n_checks++;
    if (pscore !== 4'd1 || HEX1 !== 7'b0001000) begin
      n_fail++;
      $display("FAIL wrap_ace got ps=%0d hex1=%b required 1 0001000", pscore, HEX1);
    end
    $display("shoe_wrap: pscore=%0d", pscore);
  endtask

  task automatic test_mod10();
    do_reset();
    repeat (8) drive(6'd0, 4'd0);
    drive(6'b000001, 4'd0);
    drive(6'b000010, 4'd0);
    n_checks++;
    if (pscore !== 4'd9) begin
      n_fail++;
      $display("FAIL mod10_pscore got %0d required 9", pscore);
    end
    n_checks++;
    if (HEX1 !== 7'b1000000) begin
      n_fail++;
      $display("FAIL mod10_hex1 got %b required 1000000", HEX1);
    end
    $display("mod10: pscore=%0d hex1=%b", pscore, HEX1);
  endtask
`endif

  task automatic test_mid_reset();
    do_reset();
    drive(6'b000001, 4'd4);
    drive(6'b001000, 4'd5);
    drive(6'b000010, 4'd6);
    #2;
    resetb = 1'b0;
    model_clear();
    #1;
    n_checks++;
    if ({pcard3, pscore, dscore} !== 12'd0 || cards_dealt !== 3'd0 ||
        HEX0 !== 7'b1111111 || HEX3 !== 7'b1111111 || HEX1 !== 7'b1111111) begin
      n_fail++;
      $display("FAIL midreset got ps=%0d ds=%0d dealt=%0d hex0=%b required all reset", pscore, dscore, cards_dealt, HEX0);
    end
    @(negedge slow_clock);
    resetb = 1'b1;
    drive(6'b000001, 4'd1);
    n_checks++;
    if (HEX0 !== 7'b0001000 || pscore !== 4'd1) begin
      n_fail++;
      $display("FAIL midreset_first got hex0=%b ps=%0d required 0001000 1", HEX0, pscore);
    end
    $display("mid_reset: first pscore=%0d", pscore);
  endtask

`ifdef HAND_DATAPATH_EXT_CARD_EN
  task automatic test_ext_card();
    do_reset();
    drive(6'b100000, 4'd7);
    n_checks++;
    if (dscore !== 4'd7) begin
      n_fail++;
      $display("FAIL ext_seven got %0d required 7", dscore);
    end
    drive(6'b000100, 4'd15);
    n_checks++;
    if (pcard3 !== 4'd0 || HEX2 !== 7'b1111111) begin
      n_fail++;
      $display("FAIL ext_fifteen got p3=%0d hex2=%b required 0 1111111", pcard3, HEX2);
    end
    $display("ext_card: dscore=%0d pcard3=%0d", dscore, pcard3);
  endtask
`endif

  task automatic test_random();
    logic [5:0] ld;
    do_reset();
    for (int t = 0; t < 80; t++) begin
      for (int b = 0; b < 6; b++) ld[b] = ($urandom_range(0, 3) == 0);
      drive(ld, 4'($urandom_range(0, 15)));
      n_checks++;
      if (pscore !== 4'(pscore_m()) || dscore !== 4'(dscore_m()) ||
          pcard3 !== 4'(slot_m[2]) || cards_dealt !== 3'(dealt_m)) begin
        n_fail++;
        $display("FAIL random_%0d got ps=%0d ds=%0d p3=%0d dealt=%0d required %0d %0d %0d %0d",
                 t, pscore, dscore, pcard3, cards_dealt, pscore_m(), dscore_m(), slot_m[2], dealt_m);
      end
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (hex_o[i] !== glyph_m(slot_m[i])) begin
          n_fail++;
          $display("FAIL random_%0d_hex%0d got %b required %b", t, i, hex_o[i], glyph_m(slot_m[i]));
        end
      end
      $display("random %0d: ld=%b ps=%0d ds=%0d dealt=%0d", t, ld, pscore, dscore, cards_dealt);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_deal_order();
    test_simultaneous();
`ifndef HAND_DATAPATH_EXT_CARD_EN
    test_shoe_wrap();
    test_mod10();
`else
    test_ext_card();
`endif
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
